// File: rtl/seq_mult_param.sv
// Shift-and-add multiplier (unsigned or two's complement); WIDTH cycles from start-accept to o_done.
// No backpressure: a start is taken only in IDLE/DONE and ignored while busy; the product is held until the next completion.
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_signed,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic             mode;

    logic [WIDTH:0]   ext_acc;
    logic [WIDTH:0]   ext_m;
    logic [WIDTH:0]   sum;
    logic             last;

    // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so the last step subtracts.
    always_comb begin
        ext_acc = {mode & acc[WIDTH-1], acc};
        ext_m   = {mode & m[WIDTH-1], m};
        last    = (cnt == LAST_CNT);
        sum     = ext_acc;
        if (q[0]) begin
            if (mode && last) begin
                sum = ext_acc - ext_m;
            end else begin
                sum = ext_acc + ext_m;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            m         <= '0;
            acc       <= '0;
            q         <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            o_product <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        m      <= i_a;
                        q      <= i_b;
                        acc    <= '0;
                        cnt    <= '0;
                        mode   <= i_signed;
                        state  <= CALC;
                        o_busy <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                CALC: begin
                    acc <= sum[WIDTH:1];
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        o_product <= {sum[WIDTH:1], sum[0], q[WIDTH-1:1]};
                        state     <= DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule
